// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-seg scan controller: frame snapshot, shared registered decoder, blanking gaps.
// Optional LEADING_ZERO_BLANK_EN: suppress digits above the most significant nonzero digit.
module display_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk_dis,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            q_out,
  input  logic [7:0]            seg_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int BLANK_LEN = (BLANK_CYC < 2) ? 2 : BLANK_CYC;
  localparam int CNT_MAX   = (BLANK_LEN > SCAN_DIV) ? BLANK_LEN : SCAN_DIV;
  localparam int CW        = $clog2(CNT_MAX) + 1;
  localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LEN - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic [DIGITS-1:0][3:0] digits_v;
  logic [DIGITS-1:0][3:0] shadow;
  logic [DIGITS-1:0]      dp_shadow;
  logic                   snap;
  logic                   lit;

  assign digits_v = digits_in;

  // Snapshot on leaving IDLE and at the end of the last digit's SHOW.
  always_comb begin
    snap = 1'b0;
    if (en) begin
      if (state == IDLE)
        snap = 1'b1;
      else if (state == SHOW && cnt == SHOW_LAST && idx == IDX_LAST)
        snap = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  logic [IW-1:0] msd_next;

  always_comb begin
    msd_next = '0;
    for (int i = 0; i < DIGITS; i++)
      if (digits_v[i] != 4'h0) msd_next = IW'(i);
  end

  always_ff @(posedge clk_dis) begin
    if (rst)       msd <= '0;
    else if (snap) msd <= msd_next;
  end

  assign lit = (idx <= msd);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk_dis) begin
    if (rst) begin
      shadow    <= '0;
      dp_shadow <= '0;
    end else if (snap) begin
      shadow    <= digits_v;
      dp_shadow <= dp_in;
    end
  end

  always_ff @(posedge clk_dis) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      q_out      <= '0;
      seg_out    <= 8'hFF;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          seg_out <= 8'hFF;
          an_out  <= '1;
          cnt     <= '0;
          idx     <= '0;
          if (en) begin
            q_out <= digits_v[0];
            state <= BLANK;
          end
        end
        BLANK: begin
          if (!en) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
          end else if (cnt == BLANK_LAST) begin
            // seg_in already reflects q_out: it was loaded >=2 edges ago.
            cnt   <= '0;
            state <= SHOW;
            if (lit) begin
              an_out  <= ~(DIGITS'(1) << idx);
              seg_out <= {~dp_shadow[idx] & seg_in[7], seg_in[6:0]};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (!en) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            an_out  <= '1;
            seg_out <= 8'hFF;
          end else if (cnt == SHOW_LAST) begin
            cnt     <= '0;
            an_out  <= '1;
            seg_out <= 8'hFF;
            state   <= BLANK;
            if (idx == IDX_LAST) begin
              frame_done <= 1'b1;
              idx        <= '0;
              q_out      <= digits_v[0];
            end else begin
              idx   <= idx + IW'(1);
              q_out <= shadow[idx + IW'(1)];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          an_out  <= '1;
          seg_out <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a registered common-anode hex decoder model.
// Build with LEADING_ZERO_BLANK_EN defined to exercise leading-zero suppression.
module tb_display_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic        clk_dis = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  q_out;
  logic [7:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  display_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk_dis(clk_dis), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .q_out(q_out), .seg_in(seg_in), .seg_out(seg_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk_dis = ~clk_dis;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  // Decoder resets to all segments on, so any leak onto a lit anode is visible.
  always @(posedge clk_dis) seg_in <= rst ? 8'h80 : hex7(q_out);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One digit slot: two dark cycles, then SCAN_DIV lit cycles.
  task automatic slot(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e,
                      input logic [3:0] q_e, input logic fd_e);
    @(negedge clk_dis);
    check({tag, ".an_gap"}, an_out, 4'hF);
    check({tag, ".seg_gap"}, seg_out, 8'hFF);
    check({tag, ".fd"}, frame_done, fd_e);
    check({tag, ".q"}, q_out, q_e);
    @(negedge clk_dis);
    check({tag, ".an_gap2"}, an_out, 4'hF);
    check({tag, ".fd2"}, frame_done, 1'b0);
    for (int i = 0; i < SCAN_DIV; i++) begin
      @(negedge clk_dis);
      check({tag, ".an"}, an_out, an_e);
      check({tag, ".seg"}, seg_out, seg_e);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; digits_in = 16'h4321; dp_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_dis);
      check("rst.seg", seg_out, 8'hFF);
      check("rst.an", an_out, 4'hF);
      check("rst.q", q_out, 4'h0);
      check("rst.fd", frame_done, 1'b0);
    end
    rst = 1'b0;

    // frame 1: plain 4321
    slot("f1d0", 4'b1110, 8'hF9, 4'h1, 1'b0);
    slot("f1d1", 4'b1101, 8'hA4, 4'h2, 1'b0);
    dp_in = 4'b0010;
    slot("f1d2", 4'b1011, 8'hB0, 4'h3, 1'b0);
    slot("f1d3", 4'b0111, 8'h99, 4'h4, 1'b0);

    // frame 2: dp on digit 1; mid-frame change must not tear
    slot("f2d0", 4'b1110, 8'hF9, 4'h1, 1'b1);
    slot("f2d1", 4'b1101, 8'h24, 4'h2, 1'b0);
    digits_in = 16'hFFFF; dp_in = 4'b0000;
    slot("f2d2", 4'b1011, 8'hB0, 4'h3, 1'b0);
    slot("f2d3", 4'b0111, 8'h99, 4'h4, 1'b0);

    // frame 3: all F
    slot("f3d0", 4'b1110, 8'h8E, 4'hF, 1'b1);
    slot("f3d1", 4'b1101, 8'h8E, 4'hF, 1'b0);
    slot("f3d2", 4'b1011, 8'h8E, 4'hF, 1'b0);
    digits_in = 16'h0050;
    slot("f3d3", 4'b0111, 8'h8E, 4'hF, 1'b0);

    // frame 4: 0050
    slot("f4d0", 4'b1110, 8'hC0, 4'h0, 1'b1);
    slot("f4d1", 4'b1101, 8'h92, 4'h5, 1'b0);
    digits_in = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
    slot("f4d2", 4'b1111, 8'hFF, 4'h0, 1'b0);
    slot("f4d3", 4'b1111, 8'hFF, 4'h0, 1'b0);
`else
    slot("f4d2", 4'b1011, 8'hC0, 4'h0, 1'b0);
    slot("f4d3", 4'b0111, 8'hC0, 4'h0, 1'b0);
`endif

    // frame 5: all zero
    slot("f5d0", 4'b1110, 8'hC0, 4'h0, 1'b1);
    digits_in = 16'h4321;
`ifdef LEADING_ZERO_BLANK_EN
    slot("f5d1", 4'b1111, 8'hFF, 4'h0, 1'b0);
    slot("f5d2", 4'b1111, 8'hFF, 4'h0, 1'b0);
    slot("f5d3", 4'b1111, 8'hFF, 4'h0, 1'b0);
`else
    slot("f5d1", 4'b1101, 8'hC0, 4'h0, 1'b0);
    slot("f5d2", 4'b1011, 8'hC0, 4'h0, 1'b0);
    slot("f5d3", 4'b0111, 8'hC0, 4'h0, 1'b0);
`endif

    // frame 6: drop en part way through digit 0's SHOW
    @(negedge clk_dis);
    check("f6.fd", frame_done, 1'b1);
    check("f6.q", q_out, 4'h1);
    @(negedge clk_dis);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_dis);
      check("f6.an", an_out, 4'b1110);
      check("f6.seg", seg_out, 8'hF9);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_dis);
      check("en_off.an", an_out, 4'hF);
      check("en_off.seg", seg_out, 8'hFF);
    end
    en = 1'b1;
    slot("re_d0", 4'b1110, 8'hF9, 4'h1, 1'b0);
    slot("re_d1", 4'b1101, 8'hA4, 4'h2, 1'b0);

    // reset while digit 1 is lit
    rst = 1'b1;
    @(negedge clk_dis);
    check("mrst.an", an_out, 4'hF);
    check("mrst.seg", seg_out, 8'hFF);
    check("mrst.q", q_out, 4'h0);
    check("mrst.fd", frame_done, 1'b0);
    rst = 1'b0;
    slot("pr_d0", 4'b1110, 8'hF9, 4'h1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
